ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port RAM bank between NUM_REQ requesters (GLB/SHF clients) using round-robin arbitration with optional burst locking.
- Drives the RAM wrapper's addr_r/addr_w/read_en/write_en/data_in pins. RAM read data has a fixed 1-cycle latency and is held by the wrapper until the next read.
- Returns read data to the requester that issued the read, tagged by a one-hot valid.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SRAM_WORD, 32, RAM depth
- SRAM_ADDR_WIDTH, $clog2(SRAM_WORD), RAM address width
- SRAM_WIDTH, 256, RAM data width
- REQ_ID_WIDTH, $clog2(NUM_REQ), encoded requester index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_last  in  NUM_REQ  1 = final beat of a burst (single access: tie 1)
- req_addr  in  NUM_REQ*SRAM_ADDR_WIDTH  packed addresses; requester i at slice i
- req_wdata  in  NUM_REQ*SRAM_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant; a beat transfers when valid & ready
- rsp_valid  out  NUM_REQ  one-hot read-data valid
- rsp_data  out  SRAM_WIDTH  read data, shared by all requesters
- ram_addr_r  out  SRAM_ADDR_WIDTH  RAM read address
- ram_addr_w  out  SRAM_ADDR_WIDTH  RAM write address
- ram_read_en  out  1  RAM read enable
- ram_write_en  out  1  RAM write enable
- ram_data_in  out  SRAM_WIDTH  RAM write data
- ram_data_out  in  SRAM_WIDTH  RAM read data, valid 1 cycle after ram_read_en

Behaviour:
- **Clock and reset.** One clock (clk). Synchronous active-high reset (rst).
- **Reset values.**
  - Priority pointer = 0, state = IDLE, lock owner = 0.
  - rsp_valid = 0.
  - With no valid request: req_ready = 0, ram_read_en = 0, ram_write_en = 0.
- **State machine: IDLE / LOCKED.**
  - IDLE: grant the first valid requester, searching from pointer upward modulo NUM_REQ.
  - LOCKED: grant only the lock owner. Other requesters get req_ready = 0 even if the owner's req_valid is low; the bank idles in that case.
- **Grant timing.** The grant is combinational from req_valid and registered state: req_ready is asserted the same cycle and is at most one-hot.
- **RAM command on a granted beat g (same cycle).**
  - ram_read_en = ~req_write[g]
  - ram_write_en = req_write[g]
  - ram_addr_r = ram_addr_w = req_addr[g]
  - ram_data_in = req_wdata[g]
  - With no grant: enables are 0; address and data outputs are don't-care but hold their last value.
- **Transitions.**
  - IDLE, beat granted with req_last = 0 → LOCKED, owner = g.
  - IDLE, beat granted with req_last = 1 → stay IDLE; pointer = (g+1) mod NUM_REQ.
  - LOCKED, owner beat with req_last = 1 → IDLE; pointer = (owner+1) mod NUM_REQ.
  - LOCKED, any other cycle → stay LOCKED; pointer unchanged.
- **Read response.**
  - A read granted in cycle t gives rsp_valid[g] = 1 in t+1 for exactly one cycle.
  - rsp_data = ram_data_out in that cycle.
  - Back-to-back reads from different requesters give back-to-back responses with the correct one-hot tags.
- **Writes.** No response. A write in cycle t followed by a read of the same address in t+1 returns the new data in t+2.
- **Fairness.** With all requesters continuously requesting single beats, grants rotate 0,1,2,3,0,… and no requester waits more than NUM_REQ-1 cycles.
- **Reset mid-operation.**
  - rst asserted in cycle t: state and pointer are cleared at the t edge.
  - A read granted in t-1 does NOT produce rsp_valid in t+1; rsp_valid is 0 in every cycle after a reset edge.
  - An open burst is abandoned; the requester must restart it.
- **Illegal inputs.** The owner dropping req_valid mid-burst is legal (stall). req_last on a non-granted cycle is ignored.

Decomposition:
- Shared package (ram_arb_pkg):
  - STATE_IDLE and STATE_LOCKED encodings (1 bit).
  - A function returning the round-robin next-grant index from a request vector and pointer.
- Sub-module: rr_grant_sel, combinational. Inputs: request vector, pointer. Outputs: one-hot grant and encoded index. Also reusable for the DRAM-side arbiter.
- The top level holds the FSM, pointer, response tag register and RAM muxing.

Test Plan:
- After reset, NUM_REQ=4, requesters 0..3 each issue one read (req_last=1) every cycle → req_ready one-hot sequence 0001,0010,0100,1000,0001; rsp_valid follows the same pattern 1 cycle later.
- Requester 2 writes 0xA5..A5 to addr 7 in t, requester 1 reads addr 7 in t+1 → rsp_valid=0010 in t+2 and rsp_data=0xA5..A5.
- Requester 1 bursts 3 beats (last on beat 3) while requester 3 requests continuously → req_ready stays 0010 for 3 granted beats, then 1000. The owner stalling one cycle mid-burst leaves the RAM idle and requester 3 ungranted.
- No valid requests for 5 cycles → ram_read_en=ram_write_en=0, rsp_valid=0, pointer unchanged; the next single request from requester 0 is granted immediately.
- Requester 3 read granted in t, rst=1 in t+1 → rsp_valid=0 in t+2. After release, state is IDLE, pointer=0, and simultaneous requests from 2 and 0 grant requester 0 first.
- Requester 0 opens a burst (req_last=0), rst asserted before its last beat → after reset, requester 2 is granted when 0 and 2 both request with 2 presented first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and round-robin helper for the RAM-bank port arbiters.
package ram_arb_pkg;

   typedef enum logic {
      STATE_IDLE   = 1'b0,
      STATE_LOCKED = 1'b1
   } arb_state_t;

   localparam int MAX_REQ = 8;

   // First set bit of req at or after ptr, wrapping at n; returns ptr if none set.
   function automatic logic [2:0] rr_next_idx(input logic [MAX_REQ-1:0] req,
                                              input logic [2:0]         ptr,
                                              input int                 n);
      logic [2:0] idx;
      logic       found;
      int         j;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         j = (int'(ptr) + i) % n;
         if (i < n && !found && req[j]) begin
            idx   = 3'(j);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_grant_sel.sv
// Combinational round-robin grant: one-hot grant plus encoded index.
module rr_grant_sel
   import ram_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic [2:0] sel;

   assign sel = rr_next_idx(MAX_REQ'(req), 3'(ptr), N);
   assign idx = IW'(sel);

   always_comb begin
      gnt = '0;
      if (|req) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM bank, with burst locking
// and a one-hot tag on the returned read data.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int SRAM_WORD       = 32,
   parameter int SRAM_ADDR_WIDTH = $clog2(SRAM_WORD),
   parameter int SRAM_WIDTH      = 256,
   parameter int REQ_ID_WIDTH    = $clog2(NUM_REQ)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ-1:0]                 req_write,
   input  logic [NUM_REQ-1:0]                 req_last,
   input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*SRAM_WIDTH-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic [NUM_REQ-1:0]                 rsp_valid,
   output logic [SRAM_WIDTH-1:0]              rsp_data,
   output logic [SRAM_ADDR_WIDTH-1:0]         ram_addr_r,
   output logic [SRAM_ADDR_WIDTH-1:0]         ram_addr_w,
   output logic                               ram_read_en,
   output logic                               ram_write_en,
   output logic [SRAM_WIDTH-1:0]              ram_data_in,
   input  logic [SRAM_WIDTH-1:0]              ram_data_out
);

   arb_state_t                  state;
   logic [REQ_ID_WIDTH-1:0]     ptr;
   logic [REQ_ID_WIDTH-1:0]     owner;
   logic [NUM_REQ-1:0]          req_mask;
   logic [NUM_REQ-1:0]          gnt;
   logic [REQ_ID_WIDTH-1:0]     g;
   logic                        granted;
   logic                        g_write;
   logic                        g_last;
   logic [SRAM_ADDR_WIDTH-1:0]  g_addr;
   logic [SRAM_WIDTH-1:0]       g_wdata;
   logic [SRAM_ADDR_WIDTH-1:0]  addr_q;
   logic [SRAM_WIDTH-1:0]       wdata_q;

   function automatic logic [REQ_ID_WIDTH-1:0] inc_ptr(input logic [REQ_ID_WIDTH-1:0] p);
      return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   // While locked only the owner's bit reaches the selector, so its pointer is irrelevant.
   assign req_mask = (state == STATE_LOCKED) ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;

   rr_grant_sel #(.N(NUM_REQ), .IW(REQ_ID_WIDTH)) u_sel (
      .req (req_mask),
      .ptr (ptr),
      .gnt (gnt),
      .idx (g)
   );

   assign granted = |gnt;
   assign g_write = req_write[g];
   assign g_last  = req_last[g];
   assign g_addr  = req_addr[int'(g)*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
   assign g_wdata = req_wdata[int'(g)*SRAM_WIDTH +: SRAM_WIDTH];

   assign req_ready    = gnt;
   assign ram_read_en  = granted & ~g_write;
   assign ram_write_en = granted & g_write;
   // Idle cycles keep the last command's address/data on the pins to avoid toggling.
   assign ram_addr_r   = granted ? g_addr : addr_q;
   assign ram_addr_w   = granted ? g_addr : addr_q;
   assign ram_data_in  = granted ? g_wdata : wdata_q;
   assign rsp_data     = ram_data_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= STATE_IDLE;
         ptr       <= '0;
         owner     <= '0;
         rsp_valid <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         rsp_valid <= ram_read_en ? gnt : '0;
         if (granted) begin
            addr_q  <= g_addr;
            wdata_q <= g_wdata;
         end
         case (state)
            STATE_IDLE: begin
               if (granted) begin
                  if (g_last) begin
                     ptr <= inc_ptr(g);
                  end else begin
                     state <= STATE_LOCKED;
                     owner <= g;
                  end
               end
            end
            STATE_LOCKED: begin
               if (granted && g_last) begin
                  state <= STATE_IDLE;
                  ptr   <= inc_ptr(owner);
               end
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, reset sequences, then
// random traffic against a queue-free behavioural model and a RAM stand-in.
module tb_ram_port_arbiter;

   localparam int N     = 4;
   localparam int WORDS = 32;
   localparam int AW    = 5;
   localparam int DW    = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid, req_write, req_last;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      req_ready, rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic [AW-1:0]     ram_addr_r, ram_addr_w;
   logic              ram_read_en, ram_write_en;
   logic [DW-1:0]     ram_data_in, ram_data_out;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .NUM_REQ(N), .SRAM_WORD(WORDS), .SRAM_ADDR_WIDTH(AW),
      .SRAM_WIDTH(DW), .REQ_ID_WIDTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_last(req_last),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_addr_r(ram_addr_r), .ram_addr_w(ram_addr_w),
      .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   function automatic logic [DW-1:0] init_word(input int a);
      return {8{32'h5A5A_0000 | 32'(a)}};
   endfunction

   // RAM stand-in driven only by the DUT's pins; reloaded on reset.
   logic [DW-1:0] ram [WORDS];
   always @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < WORDS; a++) ram[a] <= init_word(a);
      end else begin
         if (ram_write_en) ram[ram_addr_w] <= ram_data_in;
         if (ram_read_en)  ram_data_out    <= ram[ram_addr_r];
      end
   end

   int            n_cmp = 0;
   int            n_err = 0;
   int            m_ptr, m_owner;
   bit            m_locked;
   logic [N-1:0]  m_pend;
   logic [DW-1:0] m_pend_data;
   logic [DW-1:0] ref_mem [WORDS];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr    = 0;
      m_owner  = 0;
      m_locked = 0;
      m_pend   = '0;
      for (int a = 0; a < WORDS; a++) ref_mem[a] = init_word(a);
   endtask

   function automatic int exp_grant();
      if (m_locked) return req_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l,
                        input logic [N*AW-1:0] a, input logic [DW-1:0] d);
      req_valid = v;
      req_write = w;
      req_last  = l;
      req_addr  = a;
      req_wdata = {N{d}};
   endtask

   // Inputs are already applied (after a negedge); check, then advance one clock.
   task automatic cycle(input bit has_exp, input logic [N-1:0] er, input logic [N-1:0] ers,
                        input bit dchk, input logic [DW-1:0] ed);
      int            g;
      logic [AW-1:0] a;
      logic [N-1:0]  eg;
      #1;
      g  = exp_grant();
      eg = (g >= 0) ? (N'(1) << g) : '0;
      if (!rst) begin
         chk("req_ready", DW'(req_ready), DW'(eg));
         chk("ram_read_en", DW'(ram_read_en), DW'((g >= 0) && !req_write[g]));
         chk("ram_write_en", DW'(ram_write_en), DW'((g >= 0) && req_write[g]));
         if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            chk("ram_addr_r", DW'(ram_addr_r), DW'(a));
            chk("ram_addr_w", DW'(ram_addr_w), DW'(a));
            if (req_write[g]) chk("ram_data_in", ram_data_in, req_wdata[g*DW +: DW]);
         end
      end
      chk("rsp_valid", DW'(rsp_valid), DW'(m_pend));
      if (|m_pend) chk("rsp_data", rsp_data, m_pend_data);
      if (has_exp) begin
         chk("vec_req_ready", DW'(req_ready), DW'(er));
         chk("vec_rsp_valid", DW'(rsp_valid), DW'(ers));
         if (dchk) chk("vec_rsp_data", rsp_data, ed);
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         m_pend = '0;
         if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            if (req_write[g]) begin
               ref_mem[a] = req_wdata[g*DW +: DW];
            end else begin
               m_pend[g]   = 1'b1;
               m_pend_data = ref_mem[a];
            end
            if (!m_locked) begin
               if (req_last[g]) m_ptr = (g + 1) % N;
               else begin
                  m_locked = 1;
                  m_owner  = g;
               end
            end else if (req_last[g]) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % N;
            end
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [N-1:0]    v, w, l;
      logic [N*AW-1:0] a;
      logic [DW-1:0]   d;
      logic [N-1:0]    er, ers;
      bit              dchk;
      logic [DW-1:0]   ed;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l,
                      input logic [N*AW-1:0] a, input logic [DW-1:0] d,
                      input logic [N-1:0] er, input logic [N-1:0] ers,
                      input bit dchk, input logic [DW-1:0] ed);
      vec_t t;
      t.v = v; t.w = w; t.l = l; t.a = a; t.d = d;
      t.er = er; t.ers = ers; t.dchk = dchk; t.ed = ed;
      tbl.push_back(t);
   endtask

   localparam logic [N*AW-1:0] A_RR  = {5'd3, 5'd2, 5'd1, 5'd0};
   localparam logic [N*AW-1:0] A_RAW = {5'd0, 5'd7, 5'd7, 5'd0};
   localparam logic [N*AW-1:0] A_B1  = {5'd0, 5'd0, 5'd10, 5'd0};
   localparam logic [N*AW-1:0] A_B2  = {5'd11, 5'd0, 5'd11, 5'd0};
   localparam logic [N*AW-1:0] A_B4  = {5'd11, 5'd0, 5'd12, 5'd0};
   localparam logic [N*AW-1:0] A_R3  = {5'd4, 5'd0, 5'd0, 5'd0};
   localparam logic [DW-1:0]   D_A5  = {32{8'hA5}};
   localparam logic [DW-1:0]   D_1   = {8{32'hD1D1_0001}};
   localparam logic [DW-1:0]   D_2   = {8{32'hD2D2_0002}};
   localparam logic [DW-1:0]   D_3   = {8{32'hD3D3_0003}};

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] r;
      for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      rst = 1'b1;
      drive('0, '0, '0, '0, '0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state
      add(4'h0, 4'h0, 4'h0, '0, '0, 4'h0, 4'h0, 0, '0);
      // round robin, all four reading every cycle
      add(4'hF, 4'h0, 4'hF, A_RR, '0, 4'b0001, 4'b0000, 0, '0);
      add(4'hF, 4'h0, 4'hF, A_RR, '0, 4'b0010, 4'b0001, 1, init_word(0));
      add(4'hF, 4'h0, 4'hF, A_RR, '0, 4'b0100, 4'b0010, 1, init_word(1));
      add(4'hF, 4'h0, 4'hF, A_RR, '0, 4'b1000, 4'b0100, 1, init_word(2));
      add(4'hF, 4'h0, 4'hF, A_RR, '0, 4'b0001, 4'b1000, 1, init_word(3));
      // write then read same address
      add(4'b0100, 4'b0100, 4'hF, A_RAW, D_A5, 4'b0100, 4'b0001, 0, '0);
      add(4'b0010, 4'b0000, 4'hF, A_RAW, '0,   4'b0010, 4'b0000, 0, '0);
      add(4'h0,    4'h0,    4'h0, '0,    '0,   4'b0000, 4'b0010, 1, D_A5);
      // requester 1 burst of 3 writes with a stall, requester 3 waiting
      add(4'b0010, 4'b0010, 4'b0000, A_B1, D_1, 4'b0010, 4'b0000, 0, '0);
      add(4'b1010, 4'b0010, 4'b1000, A_B2, D_2, 4'b0010, 4'b0000, 0, '0);
      add(4'b1000, 4'b0000, 4'b1000, A_B2, '0,  4'b0000, 4'b0000, 0, '0);
      add(4'b1010, 4'b0010, 4'b1010, A_B4, D_3, 4'b0010, 4'b0000, 0, '0);
      add(4'b1000, 4'b0000, 4'b1000, A_B4, '0,  4'b1000, 4'b0000, 0, '0);
      add(4'h0,    4'h0,    4'h0,    '0,   '0,  4'b0000, 4'b1000, 1, D_2);
      // idle gap, then a single read from requester 0
      for (int k = 0; k < 5; k++) add(4'h0, 4'h0, 4'h0, '0, '0, 4'b0000, 4'b0000, 0, '0);
      add(4'b0001, 4'h0, 4'hF, '0, '0, 4'b0001, 4'b0000, 0, '0);
      add(4'h0,    4'h0, 4'h0, '0, '0, 4'b0000, 4'b0001, 1, init_word(0));

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].a, tbl[i].d);
         cycle(1, tbl[i].er, tbl[i].ers, tbl[i].dchk, tbl[i].ed);
      end

      // read from 3, then reset: no response after the reset edge
      drive(4'b1000, 4'h0, 4'hF, A_R3, '0);
      cycle(1, 4'b1000, 4'b0000, 0, '0);
      rst = 1'b1;
      drive('0, '0, '0, '0, '0);
      cycle(0, '0, '0, 0, '0);
      rst = 1'b0;
      cycle(1, 4'b0000, 4'b0000, 0, '0);
      drive(4'b0101, 4'h0, 4'hF, '0, '0);
      cycle(1, 4'b0001, 4'b0000, 0, '0);
      drive('0, '0, '0, '0, '0);
      cycle(1, 4'b0000, 4'b0001, 0, '0);

      // open burst from 0 abandoned by reset
      drive(4'b0001, 4'h0, 4'h0, '0, '0);
      cycle(1, 4'b0001, 4'b0000, 0, '0);
      rst = 1'b1;
      cycle(0, '0, '0, 0, '0);
      rst = 1'b0;
      drive(4'b0100, 4'h0, 4'hF, '0, '0);
      cycle(1, 4'b0100, 4'b0000, 0, '0);
      drive(4'b0101, 4'h0, 4'hF, '0, '0);
      cycle(1, 4'b0001, 4'b0100, 0, '0);

      // random traffic, occasional reset
      for (int k = 0; k < 400; k++) begin
         logic [N*AW-1:0] ra;
         for (int r = 0; r < N; r++) ra[r*AW +: AW] = AW'($urandom_range(0, 7));
         rst = ($urandom_range(0, 59) == 0);
         drive(N'($urandom), N'($urandom), N'($urandom), ra, rnd_word());
         cycle(0, '0, '0, 0, '0);
      end
      rst = 1'b0;
      drive('0, '0, '0, '0, '0);
      cycle(0, '0, '0, 0, '0);
      cycle(0, '0, '0, 0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
